// File: rtl/div_wb_sched.sv
// div_wb_sched: issues divide requests to the multi-cycle divider, tracks the single
// outstanding destination register, stalls the front end on hazards against it, and
// shares the register-file write port between the execute stage and the divider result
// (one-entry buffer when both want the port in the same cycle).
//
// Optional feature macro: DIV_WB_SCHED_FWD_EN
//   defined     : RAW/WAW hold released in the cycle the divider result is written
//                 (relies on register-file write-through).
//   not defined : RAW/WAW hold persists until the scheduler is back in IDLE.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ex_div_req_i/op_i/rd_addr_i   divide instruction presented by execute
//   ex_rs1_addr_i, ex_rs2_addr_i  sources of the instruction in execute
//   ex_wr_en_i/addr_i/data_i      execute-stage writeback request
//   div_req_o/op_o/rd_addr_o      start request to the divider (latched op/rd)
//   div_busy_i                    divider accepted request / computing
//   div_res_ready_i, div_res_i    one-cycle result strobe and result
//   reg_wr_en_o/addr_o/data_o     register-file write port
//   hold_o                        stall request to the pipeline controller
module div_wb_sched #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_div_req_i,
  input  logic [2:0]         ex_div_op_i,
  input  logic [RADDR_W-1:0] ex_rd_addr_i,
  input  logic [RADDR_W-1:0] ex_rs1_addr_i,
  input  logic [RADDR_W-1:0] ex_rs2_addr_i,
  input  logic               ex_wr_en_i,
  input  logic [RADDR_W-1:0] ex_wr_addr_i,
  input  logic [DATA_W-1:0]  ex_wr_data_i,
  output logic               div_req_o,
  output logic [2:0]         div_op_o,
  output logic [RADDR_W-1:0] div_rd_addr_o,
  input  logic               div_busy_i,
  input  logic               div_res_ready_i,
  input  logic [DATA_W-1:0]  div_res_i,
  output logic               reg_wr_en_o,
  output logic [RADDR_W-1:0] reg_wr_addr_o,
  output logic [DATA_W-1:0]  reg_wr_data_o,
  output logic               hold_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StPend} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]  wb_buf_q, wb_buf_d;

  logic              res_take;    // divider result is consumed this cycle
  logic              div_wr;      // divider/buffer owns the write port this cycle
  logic [DATA_W-1:0] div_wr_data;
  logic              raw_hit, waw_hit, dep_hold;

  // A ready strobe coinciding with the busy accept in REQ counts as a WAIT result.
  assign res_take = div_res_ready_i &&
                    ((state_q == StWait) || ((state_q == StReq) && div_busy_i));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wb_buf_d    = wb_buf_q;
    div_wr      = 1'b0;
    div_wr_data = div_res_i;
    unique case (state_q)
      StIdle: begin
        // hold_o is always 0 in IDLE, so any request is accepted; rd=x0 is dropped.
        if (ex_div_req_i && (ex_rd_addr_i != '0)) begin
          op_d    = ex_div_op_i;
          rd_d    = ex_rd_addr_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (div_busy_i) state_d = StWait;
      end
      StWait: ;
      StPend: begin
        if (!ex_wr_en_i) begin
          div_wr      = 1'b1;
          div_wr_data = wb_buf_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (res_take) begin
      if (!ex_wr_en_i) begin
        div_wr  = 1'b1;
        state_d = StIdle;
      end else begin
        wb_buf_d = div_res_i;
        state_d  = StPend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      wb_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      wb_buf_q <= wb_buf_d;
    end
  end

  assign raw_hit = ((ex_rs1_addr_i != '0) && (ex_rs1_addr_i == rd_q)) ||
                   ((ex_rs2_addr_i != '0) && (ex_rs2_addr_i == rd_q));
  assign waw_hit = ex_wr_en_i && (ex_wr_addr_i == rd_q);

`ifdef DIV_WB_SCHED_FWD_EN
  assign dep_hold = (raw_hit || waw_hit) && !div_wr;
`else
  assign dep_hold = raw_hit || waw_hit;
`endif

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    hold_o        = 1'b0;
    div_req_o     = 1'b0;
    reg_wr_en_o   = 1'b0;
    reg_wr_addr_o = '0;
    reg_wr_data_o = '0;
    if (rst_n) begin
      // PEND always stalls so a bubble lets the buffer drain.
      hold_o    = (state_q == StPend) ||
                  ((state_q != StIdle) && (ex_div_req_i || dep_hold));
      div_req_o = (state_q == StReq);
      if (ex_wr_en_i) begin
        reg_wr_en_o   = 1'b1;
        reg_wr_addr_o = ex_wr_addr_i;
        reg_wr_data_o = ex_wr_data_i;
      end else if (div_wr) begin
        reg_wr_en_o   = 1'b1;
        reg_wr_addr_o = rd_q;
        reg_wr_data_o = div_wr_data;
      end
    end
  end

  assign div_op_o      = op_q;
  assign div_rd_addr_o = rd_q;

endmodule

// File: tb/tb_div_wb_sched.sv
module tb_div_wb_sched;

`ifdef DIV_WB_SCHED_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_div_req_i;
  logic [2:0]  ex_div_op_i;
  logic [4:0]  ex_rd_addr_i, ex_rs1_addr_i, ex_rs2_addr_i;
  logic        ex_wr_en_i;
  logic [4:0]  ex_wr_addr_i;
  logic [31:0] ex_wr_data_i;
  logic        div_req_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_rd_addr_o;
  logic        div_busy_i, div_res_ready_i;
  logic [31:0] div_res_i;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic        hold_o;

  always #5 clk = ~clk;

  div_wb_sched #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_div_req_i(ex_div_req_i), .ex_div_op_i(ex_div_op_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .ex_wr_en_i(ex_wr_en_i), .ex_wr_addr_i(ex_wr_addr_i), .ex_wr_data_i(ex_wr_data_i),
    .div_req_o(div_req_o), .div_op_o(div_op_o), .div_rd_addr_o(div_rd_addr_o),
    .div_busy_i(div_busy_i), .div_res_ready_i(div_res_ready_i), .div_res_i(div_res_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
    .reg_wr_data_o(reg_wr_data_o), .hold_o(hold_o)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_wr_en_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexp_wr", 64'(reg_wr_addr_o), 64'h3f);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", 64'(reg_wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(reg_wr_data_o), 64'(e.data));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic clr();
    ex_div_req_i = 0; ex_div_op_i = 0; ex_rd_addr_i = 0;
    ex_rs1_addr_i = 0; ex_rs2_addr_i = 0;
    ex_wr_en_i = 0; ex_wr_addr_i = 0; ex_wr_data_i = 0;
    div_busy_i = 0; div_res_ready_i = 0; div_res_i = 0;
  endtask

  // Present a divide in IDLE, then one REQ cycle where busy is seen.
  task automatic issue(input logic [4:0] rd, input logic [2:0] op);
    ex_div_req_i = 1; ex_rd_addr_i = rd; ex_div_op_i = op;
    smp();
    check("issue_hold", 64'(hold_o), 0);
    nxt();
    ex_div_req_i = 0; ex_rd_addr_i = 0; ex_div_op_i = 0;
    div_busy_i = 1;
    smp();
    check("req", 64'(div_req_o), 1);
    check("req_rd", 64'(div_rd_addr_o), 64'(rd));
    check("req_op", 64'(div_op_o), 64'(op));
    nxt();
  endtask

  initial begin
    clr();
    rst_n = 0;
    // Outputs must be gated even with live inputs during reset.
    ex_wr_en_i = 1; ex_wr_addr_i = 4; ex_wr_data_i = 44; ex_div_req_i = 1; ex_rd_addr_i = 3;
    #3;
    check("rst_wr_en", 64'(reg_wr_en_o), 0);
    check("rst_wr_addr", 64'(reg_wr_addr_o), 0);
    check("rst_wr_data", 64'(reg_wr_data_o), 0);
    check("rst_hold", 64'(hold_o), 0);
    check("rst_req", 64'(div_req_o), 0);
    check("rst_rd", 64'(div_rd_addr_o), 0);
    check("rst_op", 64'(div_op_o), 0);
    clr();
    @(negedge clk); #2 rst_n = 1;
    nxt();

    // Execute-stage write passes through in IDLE.
    ex_wr_en_i = 1; ex_wr_addr_i = 12; ex_wr_data_i = 32'hC0FFEE;
    push(12, 32'hC0FFEE);
    smp();
    check("pass_en", 64'(reg_wr_en_o), 1);
    nxt();
    clr();

    // DIV x5, RAW stall while waiting, one WAW stall, direct writeback.
    issue(5, 3'd4);
    ex_rs1_addr_i = 5;
    for (int i = 0; i < 31; i++) begin
      div_busy_i = 1;
      if (i == 10) begin
        ex_wr_en_i = 1; ex_wr_addr_i = 5; ex_wr_data_i = 32'hDEAD;
        push(5, 32'hDEAD);
      end else begin
        ex_wr_en_i = 0;
      end
      smp();
      check("wait_noreq", 64'(div_req_o), 0);
      check("raw_hold", 64'(hold_o), 1);
      nxt();
    end
    ex_wr_en_i = 0;
    div_res_ready_i = 1; div_res_i = 32'h1234;
    push(5, 32'h1234);
    smp();
    check("direct_en", 64'(reg_wr_en_o), 1);
    check("raw_wr_hold", 64'(hold_o), Fwd ? 64'd0 : 64'd1);
    nxt();
    div_busy_i = 0;
    div_res_ready_i = 1; div_res_i = 32'h7777; // stray strobe in IDLE: ignored
    smp();
    check("idle_hold", 64'(hold_o), 0);
    check("stray_en", 64'(reg_wr_en_o), 0);
    nxt();
    clr();

    // Collision: execute writes x7 while result arrives; buffer drains after a busy PEND.
    issue(5, 3'd6);
    div_res_ready_i = 1; div_res_i = 32'h5555;
    ex_wr_en_i = 1; ex_wr_addr_i = 7; ex_wr_data_i = 32'hAAAA;
    push(7, 32'hAAAA);
    smp();
    check("coll_hold", 64'(hold_o), 0);
    nxt();
    div_busy_i = 0; div_res_ready_i = 0;
    ex_wr_addr_i = 9; ex_wr_data_i = 32'h9999;
    push(9, 32'h9999);
    smp();
    check("pend_hold1", 64'(hold_o), 1);
    nxt();
    ex_wr_en_i = 0;
    push(5, 32'h5555);
    smp();
    check("pend_hold2", 64'(hold_o), 1);
    check("drain_en", 64'(reg_wr_en_o), 1);
    nxt();
    smp();
    check("post_pend_hold", 64'(hold_o), 0);
    check("post_pend_req", 64'(div_req_o), 0);
    nxt();

    // rd = x0 is dropped.
    ex_div_req_i = 1; ex_rd_addr_i = 0; ex_div_op_i = 3'd5;
    smp();
    check("x0_hold", 64'(hold_o), 0);
    nxt();
    clr();
    smp();
    check("x0_noreq", 64'(div_req_o), 0);
    check("x0_nowr", 64'(reg_wr_en_o), 0);
    nxt();

    // Second divide during WAIT stalls; accepted the cycle after the first result writes.
    issue(6, 3'd7);
    ex_div_req_i = 1; ex_rd_addr_i = 8; ex_div_op_i = 3'd4;
    smp();
    check("dual_hold", 64'(hold_o), 1);
    nxt();
    div_res_ready_i = 1; div_res_i = 32'h6666;
    push(6, 32'h6666);
    smp();
    check("dual_wr_hold", 64'(hold_o), 1);
    nxt();
    div_res_ready_i = 0; div_busy_i = 0;
    smp();
    check("dual_acc_hold", 64'(hold_o), 0);
    check("dual_acc_req", 64'(div_req_o), 0);
    nxt();
    ex_div_req_i = 0; ex_rd_addr_i = 0;
    // Busy and ready in the same REQ cycle: written directly.
    div_busy_i = 1; div_res_ready_i = 1; div_res_i = 32'h8888;
    push(8, 32'h8888);
    smp();
    check("req2", 64'(div_req_o), 1);
    check("req2_rd", 64'(div_rd_addr_o), 8);
    check("req2_wr", 64'(reg_wr_en_o), 1);
    nxt();
    clr();
    smp();
    check("req2_done", 64'(div_req_o), 0);
    nxt();

    // Reset in WAIT: outputs drop at once, no writeback afterwards.
    issue(10, 3'd4);
    ex_wr_en_i = 1; ex_wr_addr_i = 3; ex_wr_data_i = 32'h33;
    ex_rs2_addr_i = 10;
    #1 rst_n = 0;
    #1;
    check("mid_rst_wr", 64'(reg_wr_en_o), 0);
    check("mid_rst_hold", 64'(hold_o), 0);
    check("mid_rst_req", 64'(div_req_o), 0);
    @(negedge clk); #2;
    clr();
    rst_n = 1;
    nxt();
    div_res_ready_i = 1; div_res_i = 32'hBAD;
    smp();
    check("post_rst_wr", 64'(reg_wr_en_o), 0);
    check("post_rst_req", 64'(div_req_o), 0);
    check("post_rst_hold", 64'(hold_o), 0);
    nxt();
    clr();
    nxt();

    check("sb_empty", 64'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
